exec_dispatch: RTL and testbench
================================

EXEC_DISPATCH -- requirements
Module: exec_dispatch

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 3, number of execution-unit channels (legal 2..4).
REQ-002 SHALL have parameter ROB_W, default 6, ROB tag width.
REQ-003 SHALL have parameter ENABLE_C_EXTENSION, default 0; PC_BITS = 31 if set, else 30.
REQ-004 SHALL have port cpu_clock_i  in  1  sole clock.
REQ-005 SHALL have port cpu_reset_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush_i  in  1  pipeline flush.
REQ-007 SHALL have port valid_i  in  1  uop offered by register-read stage.
REQ-008 SHALL have port ready_o  out  1  dispatcher can accept.
REQ-009 SHALL have ports rob_i  in  ROB_W; opcode_i  in  7; dest_i  in  6; pc_i  in  PC_BITS; all uop fields.
REQ-010 SHALL have ports rs1_data_i, rs2_data_i, immediate_i  in  32 each; imm_i  in  1  select immediate as operand B.
REQ-011 SHALL have port unit_sel_i  in  NUM_UNITS  one-hot target unit.
REQ-012 SHALL have port wakeup_en_i  in  1  uop writes a physical register.
REQ-013 SHALL have per-unit packed outputs uop_valid_o [NUM_UNITS], uop_a_o/uop_b_o/uop_imm_o [NUM_UNITS][32], uop_opc_o [NUM_UNITS][7], uop_rob_o [NUM_UNITS][ROB_W], uop_dest_o [NUM_UNITS][6], uop_pc_o [NUM_UNITS][PC_BITS].
REQ-014 SHALL have port uop_ready_i  in  NUM_UNITS  per-unit consume.
REQ-015 SHALL have ports wakeup_valid_o  out  1; wakeup_dest_o  out  6.
REQ-016 SHALL have port stall_cnt_o  out  16  saturating backpressure counter.

Function
REQ-017 Accept = valid_i & ready_o & !flush_i; no state change on un-accepted cycles except drain and counter.
REQ-018 Operand mapping: a = rs1_data_i; b = imm_i ? immediate_i : rs2_data_i; imm = immediate_i; pc, opc, rob, dest passed unmodified.
REQ-019 Multi-hot unit_sel_i: lowest set bit wins; zero-hot: accepted, no unit loaded (nop), wakeup still honoured.
REQ-020 Each unit SHALL own a 2-entry slot: output register (drives uop_*_o) plus skid entry; transfer when uop_valid_o[u] & uop_ready_i[u].
REQ-021 Accepted uop loads output register if empty or transferring this cycle, else skid entry; latency accept->uop_valid_o = 1 cycle.
REQ-022 On transfer with skid full, skid moves to output register same edge; per-unit order strictly FIFO.
REQ-023 ready_o = no skid entry occupied in any unit; derived from registered state only (no path from uop_ready_i).
REQ-024 Skid full and a new accept to same unit SHALL be impossible by REQ-023; no uop ever dropped or duplicated.
REQ-025 wakeup_valid_o pulses exactly the cycle after an accept with wakeup_en_i=1, wakeup_dest_o = dest_i of that uop, independent of downstream stall.
REQ-026 flush_i SHALL clear all output/skid valids and wakeup_valid_o on that edge, overriding accept and transfer; ready_o = 1 next cycle.
REQ-027 stall_cnt_o increments when valid_i & !ready_o & !flush_i, saturates at 16'hFFFF, unaffected by flush.
REQ-028 Data fields of empty entries are don't-care; valids alone define content.

Reset
REQ-029 On cpu_reset_i high at clock edge: all uop_valid_o=0, skid valids=0, wakeup_valid_o=0, stall_cnt_o=0, ready_o=1 next cycle; data registers unreset.
REQ-030 Reset mid-stall SHALL discard buffered uops with precedence over flush, accept and transfer.

Structure
REQ-031 Package exec_dispatch_pkg SHALL hold uop struct (a, b, imm, opc, rob, dest, pc) and unit index constants UNIT_ALU=0, UNIT_BRANCH=1, UNIT_VALU=2.
REQ-032 One sub-module exec_dispatch_slot (2-entry skid per unit) SHALL be instantiated NUM_UNITS times via generate.

Verification
REQ-033 Accept rob=5, unit_sel=001, imm_i=1, imm=0x10, all ready -> next cycle uop_valid_o[0]=1, uop_b_o[0]=0x10, others 0.
REQ-034 Unit 1 ready=0, two uops rob=1,2 to unit 1 -> ready_o=0 after second; raise ready -> rob 1 then rob 2 issued in order, ready_o=1 after skid drains.
REQ-035 Unit 1 skid full, valid_i held 4 cycles -> stall_cnt_o=4; preload 0xFFFE and stall 3 cycles -> 0xFFFF.
REQ-036 Flush with both entries of unit 0 full and simultaneous valid_i -> all valids 0 next cycle, no wakeup, ready_o=1.
REQ-037 unit_sel=110, wakeup_en=1, dest=9 -> only unit 1 loaded; wakeup_valid_o=1, dest=9 one cycle later; unit_sel=000 -> wakeup only.
REQ-038 Reset asserted with skid entries full -> next cycle all valids 0, stall_cnt_o=0, ready_o=1.

Source files
------------

// File: rtl/exec_dispatch_pkg.sv
// rtl/exec_dispatch_pkg.sv - shared uop type, unit indices and operand helper for exec_dispatch
package exec_dispatch_pkg;

  // Struct fields are sized for the widest legal configuration.
  // Narrower configurations zero-extend on the way in and slice on the way out.
  localparam int ROB_MAX_W = 16;
  localparam int PC_MAX_W  = 31;

  localparam int UNIT_ALU    = 0;
  localparam int UNIT_BRANCH = 1;
  localparam int UNIT_VALU   = 2;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [31:0]          imm;
    logic [6:0]           opc;
    logic [ROB_MAX_W-1:0] rob;
    logic [5:0]           dest;
    logic [PC_MAX_W-1:0]  pc;
  } uop_t;

  // Operand B is either the immediate or the second register read.
  function automatic logic [31:0] sel_operand_b(input logic        use_imm,
                                                input logic [31:0] immediate,
                                                input logic [31:0] rs2);
    return use_imm ? immediate : rs2;
  endfunction

endpackage

// File: rtl/exec_dispatch_if.sv
// rtl/exec_dispatch_if.sv - valid/ready uop channel between dispatch stages
interface exec_dispatch_if;
  import exec_dispatch_pkg::*;

  logic valid;
  logic ready;
  uop_t uop;

  modport master (output valid, output uop, input ready);
  modport slave  (input valid, input uop, output ready);

endinterface

// File: rtl/exec_dispatch_slot.sv
// rtl/exec_dispatch_slot.sv - per-unit 2-entry buffer: output register plus one skid entry
module exec_dispatch_slot
  import exec_dispatch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  exec_dispatch_if.slave  in_if,
  exec_dispatch_if.master out_if
);

  logic out_v_q;
  logic skid_v_q;
  uop_t out_q;
  uop_t skid_q;
  logic xfer;

  assign xfer         = out_v_q & out_if.ready;
  // in_if.ready reports "skid entry free"; the top only loads when every skid is free.
  assign in_if.ready  = ~skid_v_q;
  assign out_if.valid = out_v_q;
  assign out_if.uop   = out_q;

  // Occupancy: reset and flush empty both entries; otherwise FIFO fill/drain.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (xfer) begin
      out_v_q  <= skid_v_q | in_if.valid;
      skid_v_q <= 1'b0;
    end else if (in_if.valid) begin
      if (out_v_q) skid_v_q <= 1'b1;
      else         out_v_q  <= 1'b1;
    end
  end

  // Payload: skid drains into the output register ahead of any new uop.
  always_ff @(posedge clk_i) begin
    if (xfer && skid_v_q) begin
      out_q <= skid_q;
    end else if (in_if.valid && (!out_v_q || xfer)) begin
      out_q <= in_if.uop;
    end
    if (in_if.valid && out_v_q && !xfer) begin
      skid_q <= in_if.uop;
    end
  end

endmodule

// File: rtl/exec_dispatch.sv
// rtl/exec_dispatch.sv - routes register-read uops to per-unit skid slots and emits wakeups
module exec_dispatch
  import exec_dispatch_pkg::*;
#(
  parameter  int NUM_UNITS          = 3,
  parameter  int ROB_W              = 6,
  parameter  int ENABLE_C_EXTENSION = 0,
  localparam int PC_BITS            = (ENABLE_C_EXTENSION != 0) ? 31 : 30
) (
  input  logic                              cpu_clock_i,
  input  logic                              cpu_reset_i,
  input  logic                              flush_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [ROB_W-1:0]                  rob_i,
  input  logic [6:0]                        opcode_i,
  input  logic [5:0]                        dest_i,
  input  logic [PC_BITS-1:0]                pc_i,
  input  logic [31:0]                       rs1_data_i,
  input  logic [31:0]                       rs2_data_i,
  input  logic [31:0]                       immediate_i,
  input  logic                              imm_i,
  input  logic [NUM_UNITS-1:0]              unit_sel_i,
  input  logic                              wakeup_en_i,
  output logic [NUM_UNITS-1:0]              uop_valid_o,
  output logic [NUM_UNITS-1:0][31:0]        uop_a_o,
  output logic [NUM_UNITS-1:0][31:0]        uop_b_o,
  output logic [NUM_UNITS-1:0][31:0]        uop_imm_o,
  output logic [NUM_UNITS-1:0][6:0]         uop_opc_o,
  output logic [NUM_UNITS-1:0][ROB_W-1:0]   uop_rob_o,
  output logic [NUM_UNITS-1:0][5:0]         uop_dest_o,
  output logic [NUM_UNITS-1:0][PC_BITS-1:0] uop_pc_o,
  input  logic [NUM_UNITS-1:0]              uop_ready_i,
  output logic                              wakeup_valid_o,
  output logic [5:0]                        wakeup_dest_o,
  output logic [15:0]                       stall_cnt_o
);

  logic [NUM_UNITS-1:0] sel_lo;
  logic [NUM_UNITS-1:0] skid_free;
  logic [NUM_UNITS-1:0] unused_hi;
  logic                 accept;
  uop_t                 uop_in;
  logic                 wakeup_valid_q;
  logic [5:0]           wakeup_dest_q;
  logic [15:0]          stall_cnt_q;

  // Isolate the lowest set bit so a multi-hot select loads exactly one unit.
  assign sel_lo = unit_sel_i & (~unit_sel_i + NUM_UNITS'(1));

  // Only registered skid state feeds ready_o, keeping uop_ready_i off this path.
  assign ready_o = &skid_free;
  assign accept  = valid_i & ready_o & ~flush_i;

  // Pack the incoming fields into the shared uop record.
  always_comb begin
    uop_in      = '0;
    uop_in.a    = rs1_data_i;
    uop_in.b    = sel_operand_b(imm_i, immediate_i, rs2_data_i);
    uop_in.imm  = immediate_i;
    uop_in.opc  = opcode_i;
    uop_in.rob  = ROB_MAX_W'(rob_i);
    uop_in.dest = dest_i;
    uop_in.pc   = PC_MAX_W'(pc_i);
  end

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    exec_dispatch_if in_if ();
    exec_dispatch_if out_if ();

    assign in_if.valid  = accept & sel_lo[u];
    assign in_if.uop    = uop_in;
    assign skid_free[u] = in_if.ready;
    assign out_if.ready = uop_ready_i[u];

    exec_dispatch_slot u_slot (
      .clk_i   (cpu_clock_i),
      .rst_i   (cpu_reset_i),
      .flush_i (flush_i),
      .in_if   (in_if),
      .out_if  (out_if)
    );

    assign uop_valid_o[u] = out_if.valid;
    assign uop_a_o[u]     = out_if.uop.a;
    assign uop_b_o[u]     = out_if.uop.b;
    assign uop_imm_o[u]   = out_if.uop.imm;
    assign uop_opc_o[u]   = out_if.uop.opc;
    assign uop_rob_o[u]   = out_if.uop.rob[ROB_W-1:0];
    assign uop_dest_o[u]  = out_if.uop.dest;
    assign uop_pc_o[u]    = out_if.uop.pc[PC_BITS-1:0];
    // Upper padding bits of rob/pc are always zero here and never leave the block.
    assign unused_hi[u]   = ^{out_if.uop.rob, out_if.uop.pc};
  end

  // Wakeup fires the cycle after an accepted writer, regardless of unit backpressure.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i || flush_i) begin
      wakeup_valid_q <= 1'b0;
    end else begin
      wakeup_valid_q <= accept & wakeup_en_i;
    end
  end

  // Wakeup destination is only meaningful while wakeup_valid_o is high.
  always_ff @(posedge cpu_clock_i) begin
    if (accept && wakeup_en_i) begin
      wakeup_dest_q <= dest_i;
    end
  end

  // Count offered-but-refused cycles, saturating; flush cycles are not stalls.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      stall_cnt_q <= 16'h0000;
    end else if (valid_i && !ready_o && !flush_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign wakeup_valid_o = wakeup_valid_q;
  assign wakeup_dest_o  = wakeup_dest_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_exec_dispatch.sv
// tb/tb_exec_dispatch.sv - directed self-checking bench for exec_dispatch
module tb_exec_dispatch;
  import exec_dispatch_pkg::*;

  localparam int NU  = 3;
  localparam int RW  = 6;
  localparam int PCB = 30;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic [RW-1:0]          rob;
  logic [6:0]             opc;
  logic [5:0]             dest;
  logic [PCB-1:0]         pc;
  logic                   imm_sel;
  logic [NU-1:0]          unit_sel;
  logic                   wakeup_en;
  logic [NU-1:0]          uop_valid;
  logic [NU-1:0][31:0]    uop_a;
  logic [NU-1:0][31:0]    uop_b;
  logic [NU-1:0][31:0]    uop_imm;
  logic [NU-1:0][6:0]     uop_opc;
  logic [NU-1:0][RW-1:0]  uop_rob;
  logic [NU-1:0][5:0]     uop_dest;
  logic [NU-1:0][PCB-1:0] uop_pc;
  logic [NU-1:0]          uop_ready;
  logic                   wk_valid;
  logic [5:0]             wk_dest;
  logic [15:0]            stall_cnt;

  int err_cnt;
  int chk_cnt;

  exec_dispatch_if stim_if ();

  exec_dispatch #(.NUM_UNITS(NU), .ROB_W(RW), .ENABLE_C_EXTENSION(0)) dut (
    .cpu_clock_i    (clk),
    .cpu_reset_i    (rst),
    .flush_i        (flush),
    .valid_i        (stim_if.valid),
    .ready_o        (stim_if.ready),
    .rob_i          (rob),
    .opcode_i       (opc),
    .dest_i         (dest),
    .pc_i           (pc),
    .rs1_data_i     (stim_if.uop.a),
    .rs2_data_i     (stim_if.uop.b),
    .immediate_i    (stim_if.uop.imm),
    .imm_i          (imm_sel),
    .unit_sel_i     (unit_sel),
    .wakeup_en_i    (wakeup_en),
    .uop_valid_o    (uop_valid),
    .uop_a_o        (uop_a),
    .uop_b_o        (uop_b),
    .uop_imm_o      (uop_imm),
    .uop_opc_o      (uop_opc),
    .uop_rob_o      (uop_rob),
    .uop_dest_o     (uop_dest),
    .uop_pc_o       (uop_pc),
    .uop_ready_i    (uop_ready),
    .wakeup_valid_o (wk_valid),
    .wakeup_dest_o  (wk_dest),
    .stall_cnt_o    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [RW-1:0] r, input logic [NU-1:0] sel,
                       input logic [5:0] d, input logic wen);
    stim_if.valid = 1'b1;
    rob           = r;
    unit_sel      = sel;
    dest          = d;
    wakeup_en     = wen;
  endtask

  initial begin
    err_cnt        = 0;
    chk_cnt        = 0;
    rst            = 1'b1;
    flush          = 1'b0;
    stim_if.valid  = 1'b0;
    stim_if.uop    = '0;
    rob            = '0;
    opc            = 7'h33;
    dest           = '0;
    pc             = '0;
    imm_sel        = 1'b0;
    unit_sel       = '0;
    wakeup_en      = 1'b0;
    uop_ready      = '1;
    step();
    step();
    rst = 1'b0;

    chk("rst_valid", 32'(uop_valid), 32'h0);
    chk("rst_wakeup", 32'(wk_valid), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_ready", 32'(stim_if.ready), 32'h1);

    // Immediate routed to operand B of the ALU unit.
    offer(6'd5, 3'b001, 6'd3, 1'b0);
    imm_sel          = 1'b1;
    stim_if.uop.a    = 32'h0000AAAA;
    stim_if.uop.b    = 32'h00005555;
    stim_if.uop.imm  = 32'h00000010;
    pc               = 30'h1234;
    step();
    stim_if.valid = 1'b0;
    imm_sel       = 1'b0;
    chk("alu_valid", 32'(uop_valid), 32'h1);
    chk("alu_b", uop_b[UNIT_ALU], 32'h10);
    chk("alu_a", uop_a[UNIT_ALU], 32'hAAAA);
    chk("alu_rob", 32'(uop_rob[UNIT_ALU]), 32'd5);
    chk("alu_pc", 32'(uop_pc[UNIT_ALU]), 32'h1234);
    chk("alu_nowake", 32'(wk_valid), 32'h0);
    step();
    chk("alu_drained", 32'(uop_valid), 32'h0);

    // Branch unit stalled: two uops fill output and skid.
    uop_ready        = 3'b101;
    stim_if.uop.b    = 32'h00000022;
    offer(6'd1, 3'b010, 6'd0, 1'b0);
    step();
    chk("br1_valid", 32'(uop_valid), 32'h2);
    chk("br1_b", uop_b[UNIT_BRANCH], 32'h22);
    chk("br1_ready", 32'(stim_if.ready), 32'h1);
    offer(6'd2, 3'b010, 6'd0, 1'b0);
    step();
    stim_if.valid = 1'b0;
    chk("br2_ready", 32'(stim_if.ready), 32'h0);
    chk("br2_head", 32'(uop_rob[UNIT_BRANCH]), 32'd1);
    offer(6'd3, 3'b010, 6'd0, 1'b1);
    repeat (4) step();
    stim_if.valid = 1'b0;
    chk("stall4", 32'(stall_cnt), 32'd4);
    chk("stall_head", 32'(uop_rob[UNIT_BRANCH]), 32'd1);
    chk("stall_nowake", 32'(wk_valid), 32'h0);
    uop_ready = 3'b111;
    step();
    chk("br_order_rob", 32'(uop_rob[UNIT_BRANCH]), 32'd2);
    chk("br_order_valid", 32'(uop_valid), 32'h2);
    chk("br_ready_back", 32'(stim_if.ready), 32'h1);
    step();
    chk("br_empty", 32'(uop_valid), 32'h0);

    // Multi-hot select: lowest bit wins, wakeup issued.
    offer(6'd4, 3'b110, 6'd9, 1'b1);
    step();
    chk("mh_valid", 32'(uop_valid), 32'h2);
    chk("mh_dest", 32'(uop_dest[UNIT_BRANCH]), 32'd9);
    chk("mh_wake", 32'(wk_valid), 32'h1);
    chk("mh_wake_dest", 32'(wk_dest), 32'd9);
    offer(6'd6, 3'b000, 6'd12, 1'b1);
    step();
    stim_if.valid = 1'b0;
    wakeup_en     = 1'b0;
    chk("nop_valid", 32'(uop_valid), 32'h0);
    chk("nop_wake", 32'(wk_valid), 32'h1);
    chk("nop_wake_dest", 32'(wk_dest), 32'd12);
    step();
    chk("wake_pulse", 32'(wk_valid), 32'h0);

    // Flush with unit 0 full and a simultaneous offer.
    uop_ready = 3'b000;
    offer(6'd7, 3'b001, 6'd1, 1'b0);
    step();
    offer(6'd8, 3'b001, 6'd1, 1'b0);
    step();
    chk("fl_pre_ready", 32'(stim_if.ready), 32'h0);
    offer(6'd9, 3'b001, 6'd2, 1'b1);
    flush = 1'b1;
    step();
    flush         = 1'b0;
    stim_if.valid = 1'b0;
    wakeup_en     = 1'b0;
    chk("fl_valid", 32'(uop_valid), 32'h0);
    chk("fl_wake", 32'(wk_valid), 32'h0);
    chk("fl_ready", 32'(stim_if.ready), 32'h1);
    chk("fl_stall", 32'(stall_cnt), 32'd4);

    // Saturation of the stall counter.
    offer(6'd10, 3'b010, 6'd0, 1'b0);
    step();
    offer(6'd11, 3'b010, 6'd0, 1'b0);
    step();
    offer(6'd12, 3'b010, 6'd0, 1'b0);
    repeat (65530) step();
    chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    repeat (3) step();
    chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);

    // Reset while full and offering.
    rst = 1'b1;
    step();
    rst           = 1'b0;
    stim_if.valid = 1'b0;
    chk("rr_valid", 32'(uop_valid), 32'h0);
    chk("rr_stall", 32'(stall_cnt), 32'h0);
    chk("rr_ready", 32'(stim_if.ready), 32'h1);
    chk("rr_wake", 32'(wk_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
